// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - walks result memory and rebuilds WORD_W-bit words from byte slices
// Emits each rebuilt word on a valid/ready stream; all control outputs are registered.
module result_unloader #(
  parameter int ADDR_W  = 5,
  parameter int WORD_W  = 18,
  parameter int BYTE_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              fmt_err,
  output logic              memout_read,
  output logic [ADDR_W-1:0] memout_addr,
  output logic [1:0]        part,
  input  logic [BYTE_W-1:0] Dataout,
  output logic [WORD_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam int HI_W   = WORD_W - 2*BYTE_W;
  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_B0, S_B1, S_B2, S_PUSH, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_rem;
  logic [WORD_W-1:0]   r_res;
  logic                r_fmt_err;
  logic                r_busy;
  logic                r_done;
  logic                r_read;
  logic [1:0]          r_part;
  logic                r_valid;
  logic                w_busy;
  logic                w_done;
  logic                w_read;
  logic [1:0]          w_part;
  logic                w_valid;
  logic                w_accept;

  assign w_accept = (r_state == S_PUSH) && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_read  <= 1'b0;
      r_part  <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_read  <= w_read;
      r_part  <= w_part;
      r_valid <= w_valid;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_read      = 1'b0;
    w_part      = 2'b00;
    w_valid     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (r_wait == WAIT_LAST) begin
          w_next = S_B0;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      S_B0:   w_next = S_B1;
      S_B1:   w_next = S_B2;
      S_B2:   w_next = S_PUSH;
      S_PUSH: begin
        if (res_ready) begin
          w_next = (r_rem == REM_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    case (w_next)
      S_READ: begin
        w_busy = 1'b1;
        w_read = 1'b1;
      end
      S_B0: begin
        w_busy = 1'b1;
        w_read = 1'b1;
      end
      S_B1: begin
        w_busy = 1'b1;
        w_part = 2'b01;
      end
      S_B2: begin
        w_busy = 1'b1;
        w_part = 2'b10;
      end
      S_PUSH: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
      end
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_res     <= '0;
      r_fmt_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= base_addr;
            r_rem     <= count;
            r_fmt_err <= 1'b0;
          end
        end
        S_B0: r_res[BYTE_W-1:0]        <= Dataout;
        S_B1: r_res[2*BYTE_W-1:BYTE_W] <= Dataout;
        S_B2: begin
          r_res[WORD_W-1:2*BYTE_W] <= Dataout[HI_W-1:0];
          // Any bit above the top slice means the accumulator overflowed its word.
          if (|Dataout[BYTE_W-1:HI_W]) begin
            r_fmt_err <= 1'b1;
          end
        end
        S_PUSH: begin
          if (w_accept) begin
            r_rem  <= r_rem - REM_ONE;
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: r_addr <= r_addr;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign fmt_err     = r_fmt_err;
  assign memout_read = r_read;
  assign memout_addr = r_addr;
  assign part        = r_part;
  assign res_data    = r_res;
  assign res_valid   = r_valid;

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - directed bench for result_unloader
// Drives inputs 1ns after the rising edge and samples outputs there or at the falling edge.
module tb_result_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic        fmt_err;
  logic        memout_read;
  logic [4:0]  memout_addr;
  logic [1:0]  part;
  logic [7:0]  Dataout;
  logic [17:0] res_data;
  logic        res_valid;
  logic        res_ready;

  logic [17:0] mem [32];
  logic [17:0] rd_word;
  logic        force_hi;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt;
  int          bad_part = 0;
  int          n;
  logic [17:0] got_data [$];
  logic [4:0]  got_addr [$];

  result_unloader #(.ADDR_W(5), .WORD_W(18), .BYTE_W(8), .MEM_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .fmt_err     (fmt_err),
    .memout_read (memout_read),
    .memout_addr (memout_addr),
    .part        (part),
    .Dataout     (Dataout),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  always #5 clk = ~clk;

  // Result memory with one cycle of read latency; the slice mux is combinational.
  always @(posedge clk) begin
    if (memout_read) rd_word <= mem[memout_addr];
  end

  always_comb begin
    case (part)
      2'b00:   Dataout = rd_word[7:0];
      2'b01:   Dataout = rd_word[15:8];
      2'b10:   Dataout = force_hi ? 8'h05 : {6'b0, rd_word[17:16]};
      default: Dataout = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      got_data.push_back(res_data);
      got_addr.push_back(memout_addr);
    end
    if (done) done_cnt++;
    if (part == 2'b11) bad_part++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [4:0] b, input logic [5:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic run_until_done(input int max, output int cycles);
    cycles = 0;
    while (!done && cycles < max) begin
      cyc();
      cycles++;
    end
  endtask

  task automatic exp_out(input string tag, input logic b, input logic rd, input logic [4:0] a,
                         input logic [1:0] p, input logic v, input logic d);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".read"}, memout_read, rd);
    chk({tag, ".addr"}, memout_addr, a);
    chk({tag, ".part"}, part, p);
    chk({tag, ".valid"}, res_valid, v);
    chk({tag, ".done"}, done, d);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_addr.delete();
    done_cnt = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, ".ctl"}, {busy, done, fmt_err, memout_read, memout_addr, part, res_valid}, 0);
    chk({tag, ".data"}, res_data, 18'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; res_ready = 1'b1; force_hi = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = 18'(i * 18'h00111);
    mem[3] = 18'h2A5C3; mem[4] = 18'h01234;
    repeat (3) cyc();
    check_idle_zero("reset");
    rst = 1'b0;
    cyc();

    // T1 single word, cycle by cycle
    clear_log();
    pulse_start(5'd3, 6'd1);
    exp_out("t1.c1", 1, 1, 3, 2'b00, 0, 0); cyc();
    exp_out("t1.c2", 1, 1, 3, 2'b00, 0, 0); cyc();
    exp_out("t1.c3", 1, 0, 3, 2'b01, 0, 0); cyc();
    exp_out("t1.c4", 1, 0, 3, 2'b10, 0, 0); cyc();
    exp_out("t1.c5", 1, 0, 3, 2'b00, 1, 0);
    chk("t1.data", res_data, 18'h2A5C3); cyc();
    exp_out("t1.c6", 0, 0, 4, 2'b00, 0, 1); cyc();
    chk("t1.done_end", done, 0);
    chk("t1.beats", got_data.size(), 1);
    if (got_data.size() >= 1) chk("t1.word", got_data[0], 18'h2A5C3);
    chk("t1.done_cnt", done_cnt, 1);

    // T2 burst with address wrap
    clear_log();
    mem[30] = 18'h00001; mem[31] = 18'h3FFFF; mem[0] = 18'h10000; mem[1] = 18'h000FF;
    pulse_start(5'd30, 6'd4);
    run_until_done(60, n);
    chk("t2.latency", n, 20);
    cyc();
    chk("t2.beats", got_data.size(), 4);
    if (got_data.size() == 4) begin
      chk("t2.w0", got_data[0], 18'h00001); chk("t2.a0", got_addr[0], 30);
      chk("t2.w1", got_data[1], 18'h3FFFF); chk("t2.a1", got_addr[1], 31);
      chk("t2.w2", got_data[2], 18'h10000); chk("t2.a2", got_addr[2], 0);
      chk("t2.w3", got_data[3], 18'h000FF); chk("t2.a3", got_addr[3], 1);
    end
    chk("t2.fmt_err", fmt_err, 0);
    chk("t2.done_cnt", done_cnt, 1);

    // T3 backpressure for 10 cycles after valid rises
    clear_log();
    res_ready = 1'b0;
    pulse_start(5'd3, 6'd1);
    repeat (4) cyc();
    for (int i = 0; i < 10; i++) begin
      chk("t3.valid", res_valid, 1);
      chk("t3.data", res_data, 18'h2A5C3);
      chk("t3.read", memout_read, 0);
      chk("t3.done", done, 0);
      cyc();
    end
    res_ready = 1'b1;
    chk("t3.valid_at_accept", res_valid, 1);
    cyc();
    chk("t3.done_after", done, 1);
    chk("t3.beats", got_data.size(), 1);
    cyc();

    // T4 zero count
    clear_log();
    pulse_start(5'd7, 6'd0);
    exp_out("t4.c1", 0, 0, 7, 2'b00, 0, 1); cyc();
    chk("t4.done_end", done, 0);
    chk("t4.beats", got_data.size(), 0);

    // T5 reset while in B1
    clear_log();
    mem[0] = 18'h12345;
    pulse_start(5'd0, 6'd5);
    cyc(); cyc();
    chk("t5.in_b1", part, 2'b01);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_idle_zero("t5.after_rst");
    repeat (20) cyc();
    chk("t5.no_done", done_cnt, 0);
    chk("t5.idle", busy, 0);
    pulse_start(5'd3, 6'd1);
    run_until_done(40, n);
    chk("t5.restart_latency", n, 5);
    chk("t5.restart_beats", got_data.size(), 1);
    if (got_data.size() >= 1) chk("t5.restart_word", got_data[0], 18'h2A5C3);
    cyc();

    // T6 format error, sticky, ignored start while busy, cleared by next start
    clear_log();
    force_hi = 1'b1;
    pulse_start(5'd3, 6'd1);
    cyc(); cyc();
    base_addr = 5'd0; count = 6'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6.fmt_before_b2", fmt_err, 0);
    cyc();
    chk("t6.fmt_set", fmt_err, 1);
    chk("t6.word", res_data, 18'h1A5C3);
    chk("t6.addr_kept", memout_addr, 3);
    cyc();
    chk("t6.done", done, 1);
    chk("t6.fmt_at_done", fmt_err, 1);
    cyc();
    chk("t6.fmt_sticky", fmt_err, 1);
    chk("t6.one_beat", got_data.size(), 1);
    force_hi = 1'b0;
    pulse_start(5'd4, 6'd1);
    chk("t6.fmt_cleared", fmt_err, 0);
    run_until_done(40, n);
    cyc();
    chk("t6.clean_word", (got_data.size() >= 2) ? got_data[1] : 18'h0, 18'h01234);
    chk("t6.fmt_clean", fmt_err, 0);

    // start and rst in the same cycle
    rst = 1'b1; base_addr = 5'd9; count = 6'd2; start = 1'b1;
    cyc();
    start = 1'b0; rst = 1'b0;
    check_idle_zero("rst_wins");
    cyc();
    chk("rst_wins.still_idle", busy, 0);

    chk("part_never_11", bad_part, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
